// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between instruction fetch and the
// MEM-stage load/store unit. Each access is sequenced IDLE -> BUS -> DONE.
// Data accesses normally win, but fetch is guaranteed a slot after a run of
// STARVE_MAX data grants. Bus waits are bounded by WAIT_MAX cycles.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int WAIT_MAX   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_r_ena,
    input  logic              mem_w_ena,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stall_o,
    output logic              err_o,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    typedef enum logic {FETCH, DATA} owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);
    localparam logic [7:0] WAIT_LAST  = 8'(WAIT_MAX - 1);

    state_t            state_q;
    owner_t            owner_q;
    logic [3:0]        streak_q;
    logic [3:0]        streak_d;
    logic [7:0]        wait_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              if_done_q;
    logic              mem_done_q;
    logic              err_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;

    logic dataReq;
    logic grantFetch;

    // Grant decision and next starvation streak for a grant made this cycle
    always_comb begin
        dataReq    = mem_r_ena | mem_w_ena;
        grantFetch = if_req & (~dataReq | (streak_q == STREAK_MAX));
        streak_d   = streak_q;
        if (grantFetch) begin
            streak_d = 4'd0;
        end else if (dataReq) begin
            if (if_req) begin
                if (streak_q < STREAK_MAX) begin
                    streak_d = streak_q + 4'd1;
                end
            end else begin
                streak_d = 4'd0;
            end
        end
    end

    // Access sequencer: grant in IDLE, hold the bus in BUS, pulse done in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= FETCH;
            streak_q    <= 4'd0;
            wait_q      <= 8'd0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req | dataReq) begin
                        state_q   <= BUS;
                        bus_req_q <= 1'b1;
                        wait_q    <= 8'd0;
                        streak_q  <= streak_d;
                        if (grantFetch) begin
                            owner_q     <= FETCH;
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= if_addr;
                            bus_wdata_q <= '0;
                        end else begin
                            owner_q     <= DATA;
                            bus_we_q    <= mem_w_ena;
                            bus_addr_q  <= mem_addr;
                            bus_wdata_q <= mem_wdata;
                        end
                    end
                end
                BUS: begin
                    if (bus_ack || (wait_q == WAIT_LAST)) begin
                        state_q   <= DONE;
                        bus_req_q <= 1'b0;
                        wait_q    <= 8'd0;
                        if (owner_q == FETCH) begin
                            if_done_q <= 1'b1;
                        end else begin
                            mem_done_q <= 1'b1;
                        end
                        if (bus_ack) begin
                            if (!bus_we_q) begin
                                if (owner_q == FETCH) begin
                                    if_rdata_q <= bus_rdata;
                                end else begin
                                    mem_rdata_q <= bus_rdata;
                                end
                            end
                        end else begin
                            err_q <= 1'b1;
                            if (owner_q == FETCH) begin
                                if_rdata_q <= '0;
                            end else begin
                                mem_rdata_q <= '0;
                            end
                        end
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
    assign err_o     = err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign stall_o   = dataReq & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed accesses with a scoreboard of
// expected completions popped by an independent done-pulse monitor.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifReq = 1'b0;
    logic [31:0] ifAddr = '0;
    logic [31:0] ifRdata;
    logic        ifDone;
    logic        memREna = 1'b0;
    logic        memWEna = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] memWdata = '0;
    logic [31:0] memRdata;
    logic        memDone;
    logic        stallO;
    logic        errO;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [31:0] busRdata = '0;
    logic        busAck = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          isFetch;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t expQ[$];

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .WAIT_MAX(16)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_done(ifDone),
        .mem_r_ena(memREna), .mem_w_ena(memWEna), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_rdata(memRdata), .mem_done(memDone),
        .stall_o(stallO), .err_o(errO),
        .bus_req(busReq), .bus_we(busWe), .bus_addr(busAddr),
        .bus_wdata(busWdata), .bus_rdata(busRdata), .bus_ack(busAck)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic fReq, input logic [31:0] fAddr,
                                 input logic rEna, input logic wEna,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata);
        ifReq    = fReq;
        ifAddr   = fAddr;
        memREna  = rEna;
        memWEna  = wEna;
        memAddr  = dAddr;
        memWdata = dWdata;
    endtask

    // Called in the grant cycle; checks every BUS cycle and acks in BUS cycle ackCycle.
    // Returns in the cycle where the done pulse is expected.
    task automatic serveBus(input int ackCycle, input logic [31:0] ackData,
                            input logic expWe, input logic [31:0] expAddr,
                            input logic [31:0] expWdata);
        tick();
        for (int i = 1; i <= ackCycle; i++) begin
            @(negedge clk);
            checkOutput("busReq in BUS", busReq, 1'b1);
            checkOutput("busWe", busWe, expWe);
            checkOutput("busAddr", busAddr, expAddr);
            if (expWe) checkOutput("busWdata", busWdata, expWdata);
            checkOutput("stall in BUS", stallO, memREna | memWEna);
            if (i == ackCycle) begin
                busAck   = 1'b1;
                busRdata = ackData;
            end
            tick();
            busAck   = 1'b0;
            busRdata = '0;
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (ifDone || memDone)) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious done", {30'd0, ifDone, memDone}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("done owner", {30'd0, ifDone, memDone},
                            e.isFetch ? 32'd2 : 32'd1);
                checkOutput("done rdata", e.isFetch ? ifRdata : memRdata, e.rdata);
                checkOutput("done err", {31'd0, errO}, {31'd0, e.err});
            end
        end
    end

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checkOutput("reset busReq", busReq, 1'b0);
        checkOutput("reset ifDone", ifDone, 1'b0);
        checkOutput("reset memDone", memDone, 1'b0);
        checkOutput("reset errO", errO, 1'b0);
        checkOutput("reset ifRdata", ifRdata, 32'h0);
        checkOutput("reset memRdata", memRdata, 32'h0);
        checkOutput("reset busAddr", busAddr, 32'h0);
        checkOutput("reset stall", stallO, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Lone fetch, ack in first BUS cycle
        $display("[TB] lone fetch");
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        expQ.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
        @(negedge clk);
        checkOutput("busReq cycle0", busReq, 1'b0);
        checkOutput("stall cycle0", stallO, 1'b0);
        serveBus(1, 32'hDEADBEEF, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("ifDone cycle2", ifDone, 1'b1);
        checkOutput("stall fetch done", stallO, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Simultaneous fetch and load: load first, then fetch
        $display("[TB] fetch and load together");
        applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 32'h3000, 32'h0);
        expQ.push_back('{1'b0, 32'hAAAA0001, 1'b0});
        expQ.push_back('{1'b1, 32'h11110002, 1'b0});
        @(negedge clk);
        checkOutput("stall on request", stallO, 1'b1);
        serveBus(1, 32'hAAAA0001, 1'b0, 32'h3000, 32'h0);
        @(negedge clk);
        checkOutput("memDone load", memDone, 1'b1);
        checkOutput("stall at memDone", stallO, 1'b0);
        tick();
        memREna = 1'b0;
        serveBus(1, 32'h11110002, 1'b0, 32'h104, 32'h0);
        @(negedge clk);
        checkOutput("ifDone after load", ifDone, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Store with ack in third BUS cycle; load data must be untouched
        $display("[TB] store");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'h12345678);
        expQ.push_back('{1'b0, 32'hAAAA0001, 1'b0});
        serveBus(3, 32'hBADBAD00, 1'b1, 32'h2000, 32'h12345678);
        @(negedge clk);
        checkOutput("memDone store", memDone, 1'b1);
        checkOutput("store keeps memRdata", memRdata, 32'hAAAA0001);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Starvation: grant order D,D,D,D,F,D with both requests held
        $display("[TB] starvation");
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h4000, 32'h0);
        for (int i = 0; i < 6; i++) begin
            bit isF;
            isF = (i == 4);
            expQ.push_back('{isF, 32'h50000000 + 32'(i), 1'b0});
            serveBus(1, 32'h50000000 + 32'(i), 1'b0, isF ? 32'h200 : 32'h4000, 32'h0);
            @(negedge clk);
            checkOutput("starve done owner", {30'd0, ifDone, memDone}, isF ? 32'd2 : 32'd1);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Timeout: no ack for WAIT_MAX cycles
        $display("[TB] timeout");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h6000, 32'h0);
        expQ.push_back('{1'b0, 32'h0, 1'b1});
        tick();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checkOutput("timeout busReq", busReq, 1'b1);
            checkOutput("timeout stall", stallO, 1'b1);
            checkOutput("timeout no done", memDone, 1'b0);
            tick();
        end
        @(negedge clk);
        checkOutput("timeout memDone", memDone, 1'b1);
        checkOutput("timeout errO", errO, 1'b1);
        checkOutput("timeout memRdata", memRdata, 32'h0);
        checkOutput("timeout stall drop", stallO, 1'b0);
        tick();
        memREna = 1'b0;
        tick();

        // Ack in the last allowed BUS cycle wins over timeout
        $display("[TB] ack on timeout boundary");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h6004, 32'h0);
        expQ.push_back('{1'b0, 32'h00000077, 1'b0});
        serveBus(16, 32'h00000077, 1'b0, 32'h6004, 32'h0);
        @(negedge clk);
        checkOutput("boundary memDone", memDone, 1'b1);
        checkOutput("boundary errO", errO, 1'b0);
        tick();
        memREna = 1'b0;
        tick();

        // Reset in the middle of BUS abandons the access
        $display("[TB] reset mid-BUS");
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst   = 1'b1;
        ifReq = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst busReq", busReq, 1'b0);
        checkOutput("rst busAddr", busAddr, 32'h0);
        checkOutput("rst ifRdata", ifRdata, 32'h0);
        checkOutput("rst memRdata", memRdata, 32'h0);
        checkOutput("rst ifDone", ifDone, 1'b0);
        busAck   = 1'b1;
        busRdata = 32'hCAFEF00D;
        tick();
        busAck   = 1'b0;
        busRdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("late ack no ifDone", ifDone, 1'b0);
            checkOutput("late ack no busReq", busReq, 1'b0);
            tick();
        end

        // Normal load after reset recovery
        $display("[TB] load after reset");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h7000, 32'h0);
        expQ.push_back('{1'b0, 32'h0BADF00D, 1'b0});
        serveBus(2, 32'h0BADF00D, 1'b0, 32'h7000, 32'h0);
        @(negedge clk);
        checkOutput("recovery memDone", memDone, 1'b1);
        tick();
        memREna = 1'b0;
        tick();
        tick();

        checkOutput("queue drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
